// File: rtl/cnn_frame_sequencer.sv
// CNN frame sequencer: accepts a completed frame from the frame buffer,
// starts the CNN core, streams PIXELS bytes into it through a 2-entry
// (output register + skid) read pipeline, captures the 5-lane prediction
// and holds it until the consumer takes it.
// Optional build macro: CNN_SEQ_TIMEOUT_EN adds a watchdog that abandons a
// frame after TIMEOUT_CYCLES cycles in START/STREAM/DRAIN.
module cnn_frame_sequencer #(
    parameter int PIXELS         = 2304,
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              frame_valid,
    output logic              frame_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              cnn_ap_start,
    input  logic              cnn_ap_ready,
    input  logic              cnn_ap_done,
    output logic [7:0]        cnn_in_tdata,
    output logic              cnn_in_tvalid,
    input  logic              cnn_in_tready,
    input  logic [159:0]      cnn_out_tdata,
    input  logic              cnn_out_tvalid,
    output logic              cnn_out_tready,
    output logic [109:0]      pred_data,
    output logic              pred_valid,
    input  logic              pred_ready,
    output logic              busy,
    output logic [15:0]       frame_count,
    output logic              timeout
);

    localparam int NUM_LANES  = 5;
    localparam int LANE_IN_W  = 32;
    localparam int LANE_OUT_W = 22;
    localparam int DROP_W     = LANE_IN_W - LANE_OUT_W;
    localparam int CW         = $clog2(PIXELS + 1);

    typedef enum logic [2:0] {IDLE, START, STREAM, DRAIN, HOLD} state_t;

    state_t state, state_nxt;

    logic [CW-1:0] issue_cnt, sent_cnt;
    logic          rd_pend, out_vld, skd_vld;
    logic [7:0]    out_data, skd_data;
    logic [1:0]    occ;
    logic          streaming, active, pop, last_pop, issue, capture, tmo_hit;
    logic          start_q;
    logic [15:0]   fc_q;

    logic [NUM_LANES-1:0][LANE_OUT_W-1:0] pred_pack, pred_q;
    logic [NUM_LANES*DROP_W-1:0]          unused_hi;
    logic                                 unused_done;

    // Reads may start in START: streaming overlaps the core start handshake.
    assign streaming = (state == START) || (state == STREAM);
    assign active    = streaming || (state == DRAIN);
    assign pop       = streaming && out_vld && cnn_in_tready;
    assign last_pop  = pop && (sent_cnt == CW'(PIXELS - 1));
    // Words in flight + buffered never exceed 2, so the skid cannot overflow.
    assign occ       = {1'b0, rd_pend} + {1'b0, out_vld} + {1'b0, skd_vld};
    assign issue     = streaming && (issue_cnt < CW'(PIXELS)) && ((occ - {1'b0, pop}) < 2'd2);
    assign capture   = (state == DRAIN) && cnn_out_tvalid && !tmo_hit;

    // Keep the low 22 bits of each 32-bit lane; the upper 10 are dropped.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign pred_pack[k] = cnn_out_tdata[k*LANE_IN_W +: LANE_OUT_W];
        assign unused_hi[k*DROP_W +: DROP_W] = cnn_out_tdata[k*LANE_IN_W+LANE_OUT_W +: DROP_W];
    end
    // Core completion is not used for sequencing; the prediction stream is.
    assign unused_done = cnn_ap_done;

    assign rd_addr      = ADDR_W'(issue_cnt);
    assign cnn_in_tdata = out_data;
    assign cnn_ap_start = start_q && ap_rst_n;
    assign pred_data    = pred_q;
    assign frame_count  = fc_q;

`ifdef CNN_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_pulse;

    // Watchdog: zero on the way into START, counts while a frame is in flight.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            tmo_cnt   <= '0;
            tmo_pulse <= 1'b0;
        end else begin
            tmo_pulse <= tmo_hit;
            if (state == IDLE)
                tmo_cnt <= '0;
            else if (active)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = active && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign timeout = tmo_pulse && ap_rst_n;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
    assign tmo_hit    = 1'b0;
    assign timeout    = 1'b0;
`endif

    // State register.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next state and handshake outputs; handshakes are forced low in reset.
    always_comb begin
        state_nxt      = state;
        frame_ready    = (state == IDLE);
        busy           = (state != IDLE);
        rd_en          = ap_rst_n && issue;
        cnn_in_tvalid  = ap_rst_n && streaming && out_vld;
        cnn_out_tready = ap_rst_n && (state == DRAIN) && !tmo_hit;
        pred_valid     = ap_rst_n && (state == HOLD);
        case (state)
            IDLE:    if (frame_valid) state_nxt = START;
            START:   state_nxt = STREAM;
            STREAM:  if (last_pop) state_nxt = DRAIN;
            DRAIN:   if (cnn_out_tvalid) state_nxt = HOLD;
            HOLD:    if (pred_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (tmo_hit) state_nxt = IDLE;
    end

    // Read pipeline: rd_data lands one cycle after rd_en into the output
    // register, or into the skid when the output is stalled.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n || !streaming) begin
            issue_cnt <= '0;
            sent_cnt  <= '0;
            rd_pend   <= 1'b0;
            out_vld   <= 1'b0;
            skd_vld   <= 1'b0;
            out_data  <= '0;
            skd_data  <= '0;
        end else begin
            rd_pend <= issue;
            if (issue) issue_cnt <= issue_cnt + 1'b1;
            if (pop)   sent_cnt  <= sent_cnt + 1'b1;
            if (pop) begin
                if (skd_vld) begin
                    out_data <= skd_data;
                    skd_vld  <= rd_pend;
                    skd_data <= rd_data;
                end else begin
                    out_vld  <= rd_pend;
                    out_data <= rd_data;
                end
            end else if (rd_pend) begin
                if (out_vld) begin
                    skd_vld  <= 1'b1;
                    skd_data <= rd_data;
                end else begin
                    out_vld  <= 1'b1;
                    out_data <= rd_data;
                end
            end
        end
    end

    // Core start request: raised on frame accept, dropped after ready is seen.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n)                         start_q <= 1'b0;
        else if (state == IDLE && frame_valid) start_q <= 1'b1;
        else if (state_nxt == IDLE)            start_q <= 1'b0;
        else if (start_q && cnn_ap_ready)      start_q <= 1'b0;
    end

    // Prediction capture and completed-frame counter (wraps at 16 bits).
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            pred_q <= '0;
            fc_q   <= '0;
        end else begin
            if (capture) pred_q <= pred_pack;
            if (state == HOLD && pred_ready) fc_q <= fc_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Scoreboard bench for cnn_frame_sequencer: drivers push expected pixels and
// predictions into queues, a negedge monitor pops and compares on handshakes.
module tb_cnn_frame_sequencer;

    localparam int PIX = 2304;
`ifdef CNN_SEQ_TIMEOUT_EN
    localparam int TMO = 5000;
`else
    localparam int TMO = 1000000;
`endif

    logic         ap_clk = 1'b0, ap_rst_n = 1'b0;
    logic         frame_valid = 1'b0, frame_ready;
    logic         rd_en;
    logic [11:0]  rd_addr;
    logic [7:0]   rd_data = '0;
    logic         cnn_ap_start, cnn_ap_ready = 1'b0, cnn_ap_done = 1'b0;
    logic [7:0]   cnn_in_tdata;
    logic         cnn_in_tvalid, cnn_in_tready = 1'b1;
    logic [159:0] cnn_out_tdata = '0;
    logic         cnn_out_tvalid = 1'b0, cnn_out_tready;
    logic [109:0] pred_data;
    logic         pred_valid, pred_ready = 1'b0;
    logic         busy, timeout;
    logic [15:0]  frame_count;

    cnn_frame_sequencer #(.PIXELS(PIX), .ADDR_W(12), .TIMEOUT_CYCLES(TMO)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .cnn_ap_start(cnn_ap_start), .cnn_ap_ready(cnn_ap_ready), .cnn_ap_done(cnn_ap_done),
        .cnn_in_tdata(cnn_in_tdata), .cnn_in_tvalid(cnn_in_tvalid), .cnn_in_tready(cnn_in_tready),
        .cnn_out_tdata(cnn_out_tdata), .cnn_out_tvalid(cnn_out_tvalid), .cnn_out_tready(cnn_out_tready),
        .pred_data(pred_data), .pred_valid(pred_valid), .pred_ready(pred_ready),
        .busy(busy), .frame_count(frame_count), .timeout(timeout)
    );

    always #5 ap_clk = ~ap_clk;

    int pass_cnt = 0, chk_cnt = 0;
    int cyc = 0, pat_mode = 0, rnd_mode = 0, exp_fc = 0;
    int beat_cnt = 0, start_cyc = 0, first_cyc = 0, last_cyc = 0, tmo_seen = 0, tmo_cyc = 0;
    logic [7:0]   last_data = '0, stall_data = '0;
    logic         busy_q = 1'b0, stall_q = 1'b0, pv_seen = 1'b0;
    logic [7:0]   exp_pix[$];
    logic [109:0] exp_pred[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [7:0] pix(input int mode, input int a);
        logic [31:0] v;
        v = (mode == 0) ? a : a * 37 + 90;
        return v[7:0];
    endfunction

    always @(posedge ap_clk) cyc <= cyc + 1;

    // Frame buffer: data one cycle after rd_en.
    always @(posedge ap_clk) if (rd_en) rd_data <= pix(pat_mode, int'(rd_addr));

    // Sink back-pressure, changed just after each rising edge.
    initial forever begin
        @(posedge ap_clk); #1;
        if (rnd_mode == 0) cnn_in_tready = 1'b1;
`ifdef CNN_SEQ_TIMEOUT_EN
        else cnn_in_tready = ($urandom_range(0, 3) != 0);
`else
        else cnn_in_tready = ($urandom_range(0, 1) == 1);
`endif
    end

    // Monitor / scoreboard.
    always @(negedge ap_clk) begin
        if (busy && !busy_q) start_cyc = cyc;
        busy_q = busy;
        if (pred_valid) pv_seen = 1'b1;
        if (timeout) begin tmo_seen++; tmo_cyc = cyc; end
        if (stall_q && ap_rst_n) begin
            chk("tvalid_hold", cnn_in_tvalid, 1);
            chk("tdata_hold", cnn_in_tdata, stall_data);
        end
        stall_q    = cnn_in_tvalid && !cnn_in_tready;
        stall_data = cnn_in_tdata;
        if (cnn_in_tvalid && cnn_in_tready) begin
            if (exp_pix.size() == 0) chk("pix_extra", 1, 0);
            else chk("pixel", cnn_in_tdata, exp_pix.pop_front());
            beat_cnt++;
            if (beat_cnt == 1) first_cyc = cyc;
            last_cyc  = cyc;
            last_data = cnn_in_tdata;
        end
        if (pred_valid && pred_ready) begin
            if (exp_pred.size() == 0) chk("pred_extra", 1, 0);
            else chk("pred_data", pred_data, exp_pred.pop_front());
        end
    end

    task automatic tick(); @(posedge ap_clk); #1; endtask

    task automatic check_reset(input string p);
        chk({p, "_frame_ready"}, frame_ready, 1);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_rd_en"}, rd_en, 0);
        chk({p, "_tvalid"}, cnn_in_tvalid, 0);
        chk({p, "_ap_start"}, cnn_ap_start, 0);
        chk({p, "_out_tready"}, cnn_out_tready, 0);
        chk({p, "_pred_valid"}, pred_valid, 0);
        chk({p, "_pred_data"}, pred_data, 0);
        chk({p, "_frame_count"}, frame_count, 0);
        chk({p, "_timeout"}, timeout, 0);
    endtask

    task automatic load_frame(input int mode);
        pat_mode = mode;
        beat_cnt = 0;
        for (int i = 0; i < PIX; i++) exp_pix.push_back(pix(mode, i));
    endtask

    // Frame accepted at the second edge; returns at +1 into the START cycle.
    task automatic accept_frame();
        @(negedge ap_clk); chk("frame_ready", frame_ready, 1);
        tick(); frame_valid = 1'b1;
        tick(); frame_valid = 1'b0;
    endtask

    task automatic start_handshake();
        @(negedge ap_clk);
        chk("start_busy", busy, 1);
        chk("start_ap_start", cnn_ap_start, 1);
        chk("first_rd_en", rd_en, 1);
        chk("first_rd_addr", rd_addr, 0);
        repeat (2) begin @(negedge ap_clk); chk("ap_start_hold", cnn_ap_start, 1); end
        tick(); cnn_ap_ready = 1'b1;
        @(negedge ap_clk); chk("ap_start_until_ready", cnn_ap_start, 1);
        tick(); cnn_ap_ready = 1'b0;
        @(negedge ap_clk); chk("ap_start_drop", cnn_ap_start, 0);
    endtask

    task automatic finish_stream(input bit tp, input logic [7:0] last);
        int n = 0;
        do begin @(negedge ap_clk); n++; end while (!cnn_out_tready && n < 20000);
        chk("drain_reached", cnn_out_tready, 1);
        chk("beat_count", beat_cnt, PIX);
        chk("pix_queue_empty", exp_pix.size(), 0);
        chk("drain_rd_en", rd_en, 0);
        chk("drain_tvalid", cnn_in_tvalid, 0);
        chk("drain_entry_cycle", cyc - last_cyc, 1);
        if (tp) begin
            chk("fill_latency", first_cyc - start_cyc, 2);
            chk("full_rate", last_cyc - first_cyc, PIX - 1);
            chk("last_beat", last_data, last);
        end
    endtask

    task automatic send_pred(input logic [159:0] td, input logic [109:0] e);
        tick(); cnn_out_tdata = td; cnn_out_tvalid = 1'b1; exp_pred.push_back(e);
        tick(); cnn_out_tvalid = 1'b0;
        @(negedge ap_clk);
        chk("hold_pred_valid", pred_valid, 1);
        chk("hold_frame_ready", frame_ready, 0);
        chk("hold_out_tready", cnn_out_tready, 0);
    endtask

    task automatic release_pred(input int hold);
        repeat (hold) @(negedge ap_clk);
        tick(); pred_ready = 1'b1;
        tick(); pred_ready = 1'b0; exp_fc++;
        @(negedge ap_clk);
        chk("frame_count", frame_count, exp_fc);
        chk("idle_busy", busy, 0);
        chk("idle_frame_ready", frame_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk); check_reset("rst");
        tick(); ap_rst_n = 1'b1;

`ifdef CNN_SEQ_TIMEOUT_EN
        // Watchdog: the core never answers with a prediction.
        load_frame(0); pv_seen = 1'b0; tmo_seen = 0;
        accept_frame(); start_handshake();
        n = 0;
        while (tmo_seen == 0 && n < 7000) begin tick(); n++; end
        chk("tmo_seen", tmo_seen, 1);
        chk("tmo_cycle", tmo_cyc - start_cyc, 5000);
        chk("tmo_pulse_1cyc", timeout, 0);
        chk("tmo_idle", busy, 0);
        chk("tmo_no_pred", pv_seen, 0);
        chk("tmo_frame_count", frame_count, 0);
        chk("tmo_pix_empty", exp_pix.size(), 0);
        tmo_seen = 0;
`endif

        // Frame 1: ramp pattern, full rate, lane truncation vector.
        rnd_mode = 0; load_frame(0);
        accept_frame(); start_handshake();
        finish_stream(1'b1, 8'hFF);
        send_pred({32'h12345678, 32'h0, 32'h003FFFFF, 32'h00200000, 32'hFFC00001},
                  {22'h345678, 22'h0, 22'h3FFFFF, 22'h200000, 22'h000001});
        release_pred(3);

        // Frame 2: random back-pressure, scrambled pattern.
        rnd_mode = 1; load_frame(1);
        accept_frame(); start_handshake();
        finish_stream(1'b0, 8'h00);
        send_pred({32'h00000005, 32'hFFFFFFFF, 32'h00400000, 32'h80000000, 32'h00123456},
                  {22'h5, 22'h3FFFFF, 22'h0, 22'h0, 22'h123456});

        // Hold with frame_valid asserted: result stable, new frame refused.
        rnd_mode = 0; load_frame(0); frame_valid = 1'b1; bad = 0;
        repeat (100) begin
            @(negedge ap_clk);
            if (pred_valid !== 1'b1 || frame_ready !== 1'b0 ||
                pred_data !== {22'h5, 22'h3FFFFF, 22'h0, 22'h0, 22'h123456}) bad++;
        end
        chk("hold_stable", bad, 0);
        tick(); pred_ready = 1'b1;
        tick(); pred_ready = 1'b0; exp_fc++;
        @(negedge ap_clk);
        chk("release_idle", busy, 0);
        chk("release_frame_ready", frame_ready, 1);
        chk("release_frame_count", frame_count, exp_fc);
        @(negedge ap_clk);
        chk("restart_busy", busy, 1);
        chk("restart_ap_start", cnn_ap_start, 1);
        chk("restart_rd_addr", rd_addr, 0);
        tick(); frame_valid = 1'b0;

        // Frame 3: reset after 1000 pixels.
        n = 0;
        while (beat_cnt < 1000 && n < 5000) begin tick(); n++; end
        chk("reach_pixel_1000", beat_cnt, 1000);
        ap_rst_n = 1'b0; exp_pix.delete();
        @(posedge ap_clk); @(negedge ap_clk);
        check_reset("rst_mid");
        tick(); ap_rst_n = 1'b1; exp_fc = 0;

        // Frame 4: restarts from address 0 after the reset.
        load_frame(1);
        accept_frame(); start_handshake();
        finish_stream(1'b1, pix(1, PIX - 1));
        send_pred({32'h7, 32'h6, 32'h5, 32'h4, 32'h3}, {22'h7, 22'h6, 22'h5, 22'h4, 22'h3});
        release_pred(5);

        repeat (3) @(negedge ap_clk);
        chk("pred_queue_empty", exp_pred.size(), 0);
        chk("no_stray_timeout", tmo_seen, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
